// File: rtl/csi2_pkg.sv
// Shared CSI-2 receive definitions: byte-phase state of the RAW16->RAW8 splitter
// and the bit positions of the line/frame error vector.
package csi2_pkg;

  typedef enum logic [1:0] {
    PH_EMPTY = 2'd0,
    PH_LO    = 2'd1,
    PH_HI    = 2'd2
  } phase_e;

  localparam int ERR_W         = 3;
  localparam int ERR_SHORT_BIT = 0;
  localparam int ERR_LONG_BIT  = 1;
  localparam int ERR_ABORT_BIT = 2;

endpackage

// File: rtl/csi2_line_frame_checker.sv
// Tracks word/line position within a frame, counts completed frames and flags
// short lines, long lines and frames restarted by an early start-of-frame.
module csi2_line_frame_checker
  import csi2_pkg::*;
#(
  parameter int WORDS_PER_LINE = 256,
  parameter int LINE_COUNT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_acc,
  input  logic             sof,
  input  logic             eol,
  output logic             frame_end,
  output logic [ERR_W-1:0] err,
  output logic [15:0]      frame_cnt
);

  localparam int WW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINE_COUNT - 1);

  logic [WW-1:0]    word_q, word_d, word_eff;
  logic [LW-1:0]    line_q, line_d, line_eff;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             abort, last_word, last_line, line_end;

  // A start-of-frame word always restarts at word 0 line 0, whatever the counters say.
  always_comb begin
    abort       = sof && ((word_q != '0) || (line_q != '0));
    word_eff    = sof ? '0 : word_q;
    line_eff    = sof ? '0 : line_q;
    last_word   = (word_eff == WORD_LAST);
    last_line   = (line_eff == LINE_LAST);
    line_end    = last_word || eol;
    frame_end   = last_word && last_line;
    word_d      = word_q;
    line_d      = line_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = '0;
    if (word_acc) begin
      word_d = line_end ? '0 : word_eff + 1'b1;
      line_d = line_eff;
      if (line_end) begin
        line_d = last_line ? '0 : line_eff + 1'b1;
        if (last_line) frame_cnt_d = frame_cnt_q + 1'b1;
      end
      err_d[ERR_SHORT_BIT] = eol && !last_word;
      err_d[ERR_LONG_BIT]  = last_word && !eol;
      err_d[ERR_ABORT_BIT] = abort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '0;
      line_q      <= '0;
      frame_cnt_q <= '0;
      err_q       <= '0;
    end else begin
      word_q      <= word_d;
      line_q      <= line_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: rtl/csi2_rx_raw16_to_raw8_adapter.sv
// Splits a RAW16 AXI4-Stream into RAW8 bytes (low byte first) with registered
// outputs, marking start/end of frame and reporting line/frame framing errors.
//   state    | meaning
//   PH_EMPTY | no word held; upstream ready
//   PH_LO    | low byte presented downstream
//   PH_HI    | high byte presented; may accept the next word as it leaves
module csi2_rx_raw16_to_raw8_adapter
  import csi2_pkg::*;
#(
  parameter int WORDS_PER_LINE = 256,
  parameter int LINE_COUNT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        err_short_line,
  output logic        err_long_line,
  output logic        err_frame_abort,
  output logic [15:0] frame_cnt
);

  phase_e           phase_q, phase_d;
  logic             rdy_en_q, rdy_en_d;
  logic [7:0]       data_q, data_d, hi_q, hi_d;
  logic             valid_q, valid_d, user_q, user_d, last_q, last_d, eof_q, eof_d;
  logic             s_acc, m_acc, frame_end;
  logic [ERR_W-1:0] err;

  // rdy_en_q keeps s_axis_tready low through reset and releases it one edge later.
  assign s_axis_tready = rdy_en_q &&
                         ((phase_q == PH_EMPTY) || ((phase_q == PH_HI) && m_axis_tready));
  assign s_acc = s_axis_tvalid && s_axis_tready;
  assign m_acc = valid_q && m_axis_tready;

  always_comb begin
    phase_d  = phase_q;
    rdy_en_d = 1'b1;
    data_d   = data_q;
    hi_d     = hi_q;
    valid_d  = valid_q;
    user_d   = user_q;
    last_d   = last_q;
    eof_d    = eof_q;
    if (s_acc) begin
      phase_d = PH_LO;
      data_d  = s_axis_tdata[7:0];
      hi_d    = s_axis_tdata[15:8];
      valid_d = 1'b1;
      user_d  = s_axis_tuser;
      last_d  = 1'b0;
      eof_d   = frame_end;
    end else if (m_acc) begin
      if (phase_q == PH_LO) begin
        phase_d = PH_HI;
        data_d  = hi_q;
        user_d  = 1'b0;
        last_d  = eof_q;
      end else begin
        phase_d = PH_EMPTY;
        valid_d = 1'b0;
        user_d  = 1'b0;
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_EMPTY;
      rdy_en_q <= 1'b0;
      data_q   <= '0;
      hi_q     <= '0;
      valid_q  <= 1'b0;
      user_q   <= 1'b0;
      last_q   <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      rdy_en_q <= rdy_en_d;
      data_q   <= data_d;
      hi_q     <= hi_d;
      valid_q  <= valid_d;
      user_q   <= user_d;
      last_q   <= last_d;
      eof_q    <= eof_d;
    end
  end

  csi2_line_frame_checker #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .LINE_COUNT    (LINE_COUNT)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .word_acc (s_acc),
    .sof      (s_axis_tuser),
    .eol      (s_axis_tlast),
    .frame_end(frame_end),
    .err      (err),
    .frame_cnt(frame_cnt)
  );

  assign m_axis_tdata    = data_q;
  assign m_axis_tvalid   = valid_q;
  assign m_axis_tuser    = user_q;
  assign m_axis_tlast    = last_q;
  assign err_short_line  = err[ERR_SHORT_BIT];
  assign err_long_line   = err[ERR_LONG_BIT];
  assign err_frame_abort = err[ERR_ABORT_BIT];

endmodule
